// File: rtl/wav_tcm_mp_banked.sv
// rtl/wav_tcm_mp_banked.sv - multi-port word-interleaved banked TCM with per-bank round-robin arbitration
//
// Purpose: serves NUM_PORTS requestors from NUM_BANKS word-interleaved banks of
// behavioural SRAM. Each bank grants one in-range requester per cycle using a
// round-robin pointer. Reads return after RD_LAT cycles. Writes use byte strobes.
// Accesses at or above SIZE are accepted without arbitration, do not touch memory,
// and answer with o_error (plus o_rvalid/o_rdata = 0 for reads).
//
// Optional build macro: WAV_TCM_BYTE_PARITY_EN adds one even-parity bit per
// stored byte; a read whose word shows a parity mismatch reports o_error.
//
// Ports:
//   i_clk      clock
//   i_reset    synchronous active-high reset
//   i_cs       per-port request
//   i_addr     per-port byte address (NUM_PORTS*AWIDTH)
//   i_wr       per-port 1 = write, 0 = read
//   i_byte_wr  per-port write byte strobes (NUM_PORTS*STRB_WIDTH)
//   i_wdata    per-port write data (NUM_PORTS*DWIDTH)
//   i_sleep    blocks new acceptances
//   o_wait     per-port request not accepted this cycle (combinational)
//   o_rvalid   per-port read data valid
//   o_rdata    per-port read data, holds when o_rvalid = 0
//   o_error    per-port error response
module wav_tcm_mp_banked #(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter int STRB_WIDTH = DWIDTH / 8,
    parameter int NUM_PORTS  = 2,
    parameter int NUM_BANKS  = 4,
    parameter int SIZE       = 65536,
    parameter int RD_LAT     = 1
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic [NUM_PORTS-1:0]             i_cs,
    input  logic [NUM_PORTS*AWIDTH-1:0]      i_addr,
    input  logic [NUM_PORTS-1:0]             i_wr,
    input  logic [NUM_PORTS*STRB_WIDTH-1:0]  i_byte_wr,
    input  logic [NUM_PORTS*DWIDTH-1:0]      i_wdata,
    input  logic                             i_sleep,
    output logic [NUM_PORTS-1:0]             o_wait,
    output logic [NUM_PORTS-1:0]             o_rvalid,
    output logic [NUM_PORTS*DWIDTH-1:0]      o_rdata,
    output logic [NUM_PORTS-1:0]             o_error
);

    localparam int WORD_ADR  = $clog2(DWIDTH / 8);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int SIZE_BITS = $clog2(SIZE);
    localparam int ROW_BITS  = SIZE_BITS - WORD_ADR - BANK_BITS;
    localparam int ROWS      = 1 << ROW_BITS;
    localparam int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Storage (not reset)
    logic [DWIDTH-1:0] mem_q [NUM_BANKS][ROWS];

    // Address decode
    logic [AWIDTH-1:0]   addr_w [NUM_PORTS];
    logic [BANK_W-1:0]   bank_w [NUM_PORTS];
    logic [ROW_BITS-1:0] row_w  [NUM_PORTS];
    logic [NUM_PORTS-1:0] oor_w;
    logic                unused_addr_lo;

    always_comb begin
        unused_addr_lo = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            addr_w[p] = i_addr[p*AWIDTH +: AWIDTH];
            oor_w[p]  = |(addr_w[p] >> SIZE_BITS);
            bank_w[p] = (BANK_BITS > 0) ? addr_w[p][WORD_ADR +: BANK_W] : '0;
            row_w[p]  = addr_w[p][WORD_ADR+BANK_BITS +: ROW_BITS];
            unused_addr_lo = unused_addr_lo ^ (^addr_w[p][WORD_ADR-1:0]);
        end
    end

    // Per-bank round-robin arbitration
    logic [PTR_W-1:0]     rr_q [NUM_BANKS];
    logic [PTR_W-1:0]     rr_d [NUM_BANKS];
    logic [NUM_PORTS-1:0] grant;

    always_comb begin
        int  idx;
        int  win;
        int  n_req;
        logic found;
        grant = '0;
        rr_d  = rr_q;
        idx   = 0;
        win   = 0;
        n_req = 0;
        found = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            found = 1'b0;
            win   = 0;
            n_req = 0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                // Scan upward from the bank's pointer, wrapping at NUM_PORTS
                idx = int'(rr_q[b]) + i;
                if (idx >= NUM_PORTS) begin
                    idx = idx - NUM_PORTS;
                end
                if (i_cs[idx] && !i_sleep && !oor_w[idx] && (bank_w[idx] == BANK_W'(b))) begin
                    n_req = n_req + 1;
                    if (!found) begin
                        found = 1'b1;
                        win   = idx;
                    end
                end
            end
            if (found) begin
                grant[win] = 1'b1;
            end
            // Pointer only moves when there was real contention
            if (n_req >= 2) begin
                rr_d[b] = (win + 1 >= NUM_PORTS) ? '0 : PTR_W'(win + 1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                rr_q[b] <= '0;
            end
        end else begin
            rr_q <= rr_d;
        end
    end

    // Out-of-range requests bypass arbitration, so only sleep can stall them
    logic [NUM_PORTS-1:0] acc;
    assign o_wait = i_cs & ({NUM_PORTS{i_sleep}} | (~oor_w & ~grant));
    assign acc    = i_cs & ~o_wait;

    // Parity
    logic [NUM_PORTS-1:0] parity_bad;
`ifdef WAV_TCM_BYTE_PARITY_EN
    logic [STRB_WIDTH-1:0] par_q [NUM_BANKS][ROWS];

    function automatic logic [STRB_WIDTH-1:0] byte_par(input logic [DWIDTH-1:0] w);
        logic [STRB_WIDTH-1:0] r;
        for (int k = 0; k < STRB_WIDTH; k++) begin
            r[k] = ^w[k*8 +: 8];
        end
        return r;
    endfunction

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            parity_bad[p] = |(par_q[bank_w[p]][row_w[p]] ^ byte_par(mem_q[bank_w[p]][row_w[p]]));
        end
    end

    always_ff @(posedge i_clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (acc[p] && i_wr[p] && !oor_w[p]) begin
                for (int k = 0; k < STRB_WIDTH; k++) begin
                    if (i_byte_wr[p*STRB_WIDTH + k]) begin
                        par_q[bank_w[p]][row_w[p]][k] <= ^i_wdata[p*DWIDTH + k*8 +: 8];
                    end
                end
            end
        end
    end
`else
    assign parity_bad = '0;
`endif

    // Memory write: at most one in-range acceptance per bank, so no port conflicts
    always_ff @(posedge i_clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (acc[p] && i_wr[p] && !oor_w[p]) begin
                for (int k = 0; k < STRB_WIDTH; k++) begin
                    if (i_byte_wr[p*STRB_WIDTH + k]) begin
                        mem_q[bank_w[p]][row_w[p]][k*8 +: 8] <= i_wdata[p*DWIDTH + k*8 +: 8];
                    end
                end
            end
        end
    end

    // Response formed in the acceptance cycle; memory is read combinationally here,
    // so a read accepted right after a write to the same row sees the new data.
    logic [NUM_PORTS-1:0] acc_rv;
    logic [NUM_PORTS-1:0] acc_err;
    logic [DWIDTH-1:0]    acc_data [NUM_PORTS];

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            acc_rv[p]   = acc[p] && !i_wr[p];
            acc_err[p]  = acc[p] && (oor_w[p] || (!i_wr[p] && parity_bad[p]));
            acc_data[p] = oor_w[p] ? '0 : mem_q[bank_w[p]][row_w[p]];
        end
    end

    // Optional extra latency stage
    logic [NUM_PORTS-1:0] fin_rv;
    logic [NUM_PORTS-1:0] fin_err;
    logic [DWIDTH-1:0]    fin_data [NUM_PORTS];

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [NUM_PORTS-1:0] p1_rv_q;
            logic [NUM_PORTS-1:0] p1_err_q;
            logic [DWIDTH-1:0]    p1_data_q [NUM_PORTS];

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    p1_rv_q  <= '0;
                    p1_err_q <= '0;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        p1_data_q[p] <= '0;
                    end
                end else begin
                    p1_rv_q   <= acc_rv;
                    p1_err_q  <= acc_err;
                    p1_data_q <= acc_data;
                end
            end

            assign fin_rv   = p1_rv_q;
            assign fin_err  = p1_err_q;
            assign fin_data = p1_data_q;
        end else begin : g_lat1
            assign fin_rv   = acc_rv;
            assign fin_err  = acc_err;
            assign fin_data = acc_data;
        end
    endgenerate

    // Output registers; rdata only reloads on a valid read
    logic [NUM_PORTS-1:0]        rvalid_q;
    logic [NUM_PORTS-1:0]        error_q;
    logic [NUM_PORTS*DWIDTH-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rvalid_q <= '0;
            error_q  <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= fin_rv;
            error_q  <= fin_err;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (fin_rv[p]) begin
                    rdata_q[p*DWIDTH +: DWIDTH] <= fin_data[p];
                end
            end
        end
    end

    assign o_rvalid = rvalid_q;
    assign o_error  = error_q;
    assign o_rdata  = rdata_q;

endmodule

// File: tb/tb_wav_tcm_mp_banked.sv
// tb/tb_wav_tcm_mp_banked.sv - scoreboard bench for wav_tcm_mp_banked (RD_LAT 1 and 2 side by side)
module tb_wav_tcm_mp_banked;

    localparam int NP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cs;
    logic [63:0] addr;
    logic [1:0]  wr;
    logic [7:0]  bw;
    logic [63:0] wdata;
    logic        sleep;

    logic [1:0]  w1, rv1, err1;
    logic [63:0] rd1;
    logic [1:0]  w2, rv2, err2;
    logic [63:0] rd2;

    always #5 clk = ~clk;

    wav_tcm_mp_banked #(.NUM_PORTS(2), .NUM_BANKS(4), .SIZE(65536), .RD_LAT(1)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_cs(cs), .i_addr(addr), .i_wr(wr),
        .i_byte_wr(bw), .i_wdata(wdata), .i_sleep(sleep),
        .o_wait(w1), .o_rvalid(rv1), .o_rdata(rd1), .o_error(err1)
    );

    wav_tcm_mp_banked #(.NUM_PORTS(2), .NUM_BANKS(4), .SIZE(65536), .RD_LAT(2)) u_dut2 (
        .i_clk(clk), .i_reset(rst), .i_cs(cs), .i_addr(addr), .i_wr(wr),
        .i_byte_wr(bw), .i_wdata(wdata), .i_sleep(sleep),
        .o_wait(w2), .o_rvalid(rv2), .o_rdata(rd2), .o_error(err2)
    );

    typedef struct {
        int          due;
        int          port;
        logic        rv;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t        q1[$];
    rsp_t        q2[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [31:0] model_mem [int];
    int          rr [4];
    logic [31:0] last_rd [1:2][2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_rsp(input int inst);
        rsp_t        q[$];
        rsp_t        r;
        logic [1:0]  exp_rv;
        logic [1:0]  exp_err;
        logic [1:0]  got_rv;
        logic [1:0]  got_err;
        logic [63:0] got_rd;
        q       = (inst == 1) ? q1 : q2;
        exp_rv  = '0;
        exp_err = '0;
        while (q.size() > 0 && q[0].due == cyc) begin
            r = q.pop_front();
            exp_rv[r.port]  = r.rv;
            exp_err[r.port] = r.err;
            if (r.rv) last_rd[inst][r.port] = r.data;
        end
        got_rv  = (inst == 1) ? rv1 : rv2;
        got_err = (inst == 1) ? err1 : err2;
        got_rd  = (inst == 1) ? rd1 : rd2;
        check($sformatf("rvalid_lat%0d", inst), 64'(got_rv), 64'(exp_rv));
        check($sformatf("error_lat%0d", inst), 64'(got_err), 64'(exp_err));
        for (int p = 0; p < NP; p++) begin
            check($sformatf("rdata_lat%0d_p%0d", inst, p), 64'(got_rd[p*32 +: 32]), 64'(last_rd[inst][p]));
        end
        if (inst == 1) q1 = q; else q2 = q;
    endtask

    task automatic model_step();
        bit          oor [2];
        int          bk [2];
        int          rr_n [4];
        logic [1:0]  grant;
        logic [1:0]  ew;
        logic [31:0] a;
        logic [31:0] d;
        int          key;
        int          n;
        int          win;
        int          idx;
        grant = '0;
        for (int p = 0; p < NP; p++) begin
            a      = addr[p*32 +: 32];
            oor[p] = (a[31:16] != 16'h0);
            bk[p]  = int'(a[3:2]);
        end
        for (int b = 0; b < 4; b++) begin
            rr_n[b] = rr[b];
            n   = 0;
            win = -1;
            for (int i = 0; i < NP; i++) begin
                idx = (rr[b] + i) % NP;
                if (cs[idx] && !sleep && !oor[idx] && bk[idx] == b) begin
                    n++;
                    if (win < 0) win = idx;
                end
            end
            if (win >= 0) grant[win] = 1'b1;
            if (n >= 2) rr_n[b] = (win + 1) % NP;
        end
        for (int p = 0; p < NP; p++) begin
            ew[p] = cs[p] && (sleep || (!oor[p] && !grant[p]));
        end
        check("wait_lat1", 64'(w1), 64'(ew));
        check("wait_lat2", 64'(w2), 64'(ew));
        check_rsp(1);
        check_rsp(2);
        if (rst) begin
            q1.delete();
            q2.delete();
            for (int b = 0; b < 4; b++) rr[b] = 0;
            for (int p = 0; p < NP; p++) begin
                last_rd[1][p] = '0;
                last_rd[2][p] = '0;
            end
            return;
        end
        // Reads of this cycle first, then writes
        for (int p = 0; p < NP; p++) begin
            if (cs[p] && !ew[p] && !wr[p]) begin
                a   = addr[p*32 +: 32];
                key = int'(a[15:2]);
                d   = (oor[p] || !model_mem.exists(key)) ? 32'h0 : model_mem[key];
                q1.push_back('{cyc + 1, p, 1'b1, oor[p], d});
                q2.push_back('{cyc + 2, p, 1'b1, oor[p], d});
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (cs[p] && !ew[p] && wr[p]) begin
                a = addr[p*32 +: 32];
                if (oor[p]) begin
                    q1.push_back('{cyc + 1, p, 1'b0, 1'b1, 32'h0});
                    q2.push_back('{cyc + 2, p, 1'b0, 1'b1, 32'h0});
                end else begin
                    key = int'(a[15:2]);
                    d   = model_mem.exists(key) ? model_mem[key] : 32'h0;
                    for (int k = 0; k < 4; k++) begin
                        if (bw[p*4 + k]) d[k*8 +: 8] = wdata[p*32 + k*8 +: 8];
                    end
                    model_mem[key] = d;
                end
            end
        end
        for (int b = 0; b < 4; b++) rr[b] = rr_n[b];
    endtask

    always @(negedge clk) begin
        cyc++;
        if (mon_en) model_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input bit c, input bit w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        cs[p]             = c;
        wr[p]             = w;
        addr[p*32 +: 32]  = a;
        bw[p*4 +: 4]      = s;
        wdata[p*32 +: 32] = d;
    endtask

    task automatic idle();
        cs = '0;
        wr = '0;
    endtask

    initial begin
        rst   = 1'b1;
        cs    = '0;
        addr  = '0;
        wr    = '0;
        bw    = '0;
        wdata = '0;
        sleep = 1'b0;
        for (int b = 0; b < 4; b++) rr[b] = 0;
        for (int p = 0; p < NP; p++) begin
            last_rd[1][p] = '0;
            last_rd[2][p] = '0;
        end
        repeat (3) tick();
        check("reset_rvalid_lat1", 64'(rv1), 64'h0);
        check("reset_error_lat1", 64'(err1), 64'h0);
        check("reset_rdata_lat1", rd1, 64'h0);
        check("reset_wait_lat1", 64'(w1), 64'h0);
        check("reset_rvalid_lat2", 64'(rv2), 64'h0);
        check("reset_error_lat2", 64'(err2), 64'h0);
        check("reset_rdata_lat2", rd2, 64'h0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Initialise the rows used below, then read back 0x0
        drive(0, 1, 1, 32'h0,  4'hF, 32'hA5A5_1234); tick();
        drive(0, 1, 1, 32'h4,  4'hF, 32'h1111_1111); tick();
        drive(0, 1, 1, 32'h14, 4'hF, 32'h2222_2222); tick();
        drive(0, 1, 1, 32'h8,  4'hF, 32'h0BAD_CAFE); tick();
        idle(); tick();
        drive(0, 1, 0, 32'h0, 4'h0, 32'h0); tick();
        idle(); tick(); tick();

        // Both ports contend for bank 1 for four cycles
        drive(0, 1, 0, 32'h4,  4'h0, 32'h0);
        drive(1, 1, 0, 32'h14, 4'h0, 32'h0);
        repeat (4) tick();
        idle(); tick(); tick();

        // Different banks in the same cycle
        drive(0, 1, 0, 32'h0, 4'h0, 32'h0);
        drive(1, 1, 0, 32'h8, 4'h0, 32'h0);
        tick();
        idle(); tick(); tick();

        // Byte strobes, including an all-zero strobe write
        drive(0, 1, 1, 32'h10, 4'hF, 32'hFFFF_FFFF); tick();
        drive(0, 1, 1, 32'h10, 4'h2, 32'h0000_0000); tick();
        drive(0, 1, 1, 32'h10, 4'h0, 32'h1234_5678); tick();
        drive(0, 1, 0, 32'h10, 4'h0, 32'h0); tick();
        idle(); tick(); tick();

        // Out of range read and write in the same cycle, then confirm 0x0 intact
        drive(0, 1, 0, 32'h0001_0000, 4'h0, 32'h0);
        drive(1, 1, 1, 32'h0001_0000, 4'hF, 32'hDEAD_BEEF);
        tick();
        idle(); tick();
        drive(0, 1, 0, 32'h0, 4'h0, 32'h0); tick();
        idle(); tick(); tick();

        // Back-to-back reads
        drive(0, 1, 0, 32'h0,  4'h0, 32'h0); tick();
        drive(0, 1, 0, 32'h4,  4'h0, 32'h0); tick();
        drive(0, 1, 0, 32'h8,  4'h0, 32'h0); tick();
        drive(0, 1, 0, 32'h10, 4'h0, 32'h0); tick();
        idle(); tick(); tick();

        // Read in the cycle right after a write to the same row
        drive(1, 1, 1, 32'h4, 4'hF, 32'h3333_3333); tick();
        drive(1, 1, 0, 32'h4, 4'h0, 32'h0); tick();
        idle(); tick(); tick();

        // Sleep: read accepted just before still returns; held request waits
        drive(0, 1, 0, 32'h8, 4'h0, 32'h0); tick();
        sleep = 1'b1;
        drive(0, 1, 0, 32'h0, 4'h0, 32'h0);
        repeat (3) tick();
        sleep = 1'b0;
        idle(); tick(); tick(); tick();

        // Reset with a read in flight
        drive(0, 1, 0, 32'h10, 4'h0, 32'h0); tick();
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        repeat (4) tick();

        @(negedge clk);
        #1;
        check("drain_q_lat1", 64'(q1.size()), 64'h0);
        check("drain_q_lat2", 64'(q2.size()), 64'h0);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
